// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
package systolic_pkg;

    localparam int PE_NUMBER_DEF = 64;
    localparam int WORD_SIZE_DEF = 16;
    localparam int LEN_W_DEF     = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_READ  = 3'd3,
        ST_CLEAR = 3'd4
    } seq_state_t;

    // One extra bit so the drain/result counters can hold PE_NUMBER itself.
    function automatic int res_cnt_width(input int pe_number);
        return $clog2(pe_number) + 1;
    endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// Command, input-beat and result handshakes between the bus side and the sequencer.
interface systolic_sequencer_if
    import systolic_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int PE_NUMBER = PE_NUMBER_DEF,
    parameter int LEN_W     = LEN_W_DEF
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_W-1:0]     cmd_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_data;
    logic [WORD_SIZE-1:0] in_weight [PE_NUMBER];
    logic                 res_valid;
    logic                 res_ready;
    logic [WORD_SIZE-1:0] res_data;
    logic                 res_last;

    modport master (
        output cmd_valid, cmd_len, in_valid, in_data, in_weight, res_ready,
        input  cmd_ready, in_ready, res_valid, res_data, res_last
    );

    modport slave (
        input  cmd_valid, cmd_len, in_valid, in_data, in_weight, res_ready,
        output cmd_ready, in_ready, res_valid, res_data, res_last
    );

endinterface

// File: rtl/result_skid.sv
// One-entry result register; it pulls a new word from the array only when
// it is empty or its current word leaves this cycle.
module result_skid #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 allow,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_last,
    output logic                 take,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_last
);
    assign take = allow && (!out_valid || out_ready);

    // Output register: load on take, drop when consumed, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= {WORD_SIZE{1'b0}};
            out_last  <= 1'b0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= out_valid;
            out_data  <= out_data;
            out_last  <= out_last;
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for the linear systolic array: feeds K beats, drains the skew,
// shifts PE_NUMBER results out through a one-entry skid and clears the array.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int PE_NUMBER = PE_NUMBER_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_sequencer_if.slave  bus,
    output logic                 arr_read,
    output logic                 arr_reset,
    output logic [WORD_SIZE-1:0] arr_l_d_i,
    output logic [WORD_SIZE-1:0] arr_t_w [PE_NUMBER],
    input  logic [WORD_SIZE-1:0] arr_l_d_o,
    output logic                 busy,
    output logic                 done
);
    localparam int                CW       = res_cnt_width(PE_NUMBER);
    localparam logic [CW-1:0]     CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(PE_NUMBER - 1);
    localparam logic [CW-1:0]     CNT_FULL = CW'(PE_NUMBER);
    localparam logic [LEN_W-1:0]  LEN_ZERO = LEN_W'(0);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    seq_state_t        state_r, state_s;
    logic [LEN_W-1:0]  len_r, len_s;
    logic [LEN_W-1:0]  beat_cnt_r, beat_cnt_s;
    logic [CW-1:0]     drain_cnt_r, drain_cnt_s;
    logic [CW-1:0]     res_cnt_r, res_cnt_s;
    logic              beat_s;
    logic              read_allow_s;
    logic              read_last_s;
    logic              take_s;
    logic              res_accept_s;

    assign beat_s       = (state_r == ST_FEED) && bus.in_valid;
    assign read_allow_s = (state_r == ST_READ) && (res_cnt_r < CNT_FULL) && !reset;
    assign read_last_s  = (res_cnt_r == CNT_LAST);
    assign res_accept_s = bus.res_valid && bus.res_ready;

    result_skid #(
        .WORD_SIZE (WORD_SIZE)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .allow     (read_allow_s),
        .in_data   (arr_l_d_o),
        .in_last   (read_last_s),
        .take      (take_s),
        .out_valid (bus.res_valid),
        .out_ready (bus.res_ready),
        .out_data  (bus.res_data),
        .out_last  (bus.res_last)
    );

    // Next-state, counter updates and array-side data steering.
    always_comb begin
        state_s       = state_r;
        len_s         = len_r;
        beat_cnt_s    = beat_cnt_r;
        drain_cnt_s   = drain_cnt_r;
        res_cnt_s     = res_cnt_r;
        bus.cmd_ready = 1'b0;
        bus.in_ready  = 1'b0;
        arr_l_d_i     = {WORD_SIZE{1'b0}};
        for (int j = 0; j < PE_NUMBER; j++) begin
            arr_t_w[j] = {WORD_SIZE{1'b0}};
        end
        case (state_r)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    len_s      = bus.cmd_len;
                    beat_cnt_s = LEN_ZERO;
                    state_s    = (bus.cmd_len != LEN_ZERO) ? ST_FEED : ST_DRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                bus.in_ready = 1'b1;
                // Without a beat the zeros ride the skew as a harmless bubble.
                if (beat_s) begin
                    arr_l_d_i = bus.in_data;
                    for (int j = 0; j < PE_NUMBER; j++) begin
                        arr_t_w[j] = bus.in_weight[j];
                    end
                    if (beat_cnt_r == (len_r - LEN_ONE)) begin
                        beat_cnt_s = LEN_ZERO;
                        state_s    = ST_DRAIN;
                    end else begin
                        beat_cnt_s = beat_cnt_r + LEN_ONE;
                        state_s    = ST_FEED;
                    end
                end else begin
                    state_s = ST_FEED;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == CNT_LAST) begin
                    drain_cnt_s = CNT_ZERO;
                    state_s     = ST_READ;
                end else begin
                    drain_cnt_s = drain_cnt_r + CNT_ONE;
                    state_s     = ST_DRAIN;
                end
            end
            ST_READ: begin
                if (take_s) begin
                    res_cnt_s = res_cnt_r + CNT_ONE;
                end else begin
                    res_cnt_s = res_cnt_r;
                end
                if (res_accept_s && bus.res_last) begin
                    res_cnt_s = CNT_ZERO;
                    state_s   = ST_CLEAR;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_CLEAR: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            len_r       <= LEN_ZERO;
            beat_cnt_r  <= LEN_ZERO;
            drain_cnt_r <= CNT_ZERO;
            res_cnt_r   <= CNT_ZERO;
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            beat_cnt_r  <= beat_cnt_s;
            drain_cnt_r <= drain_cnt_s;
            res_cnt_r   <= res_cnt_s;
        end
    end

    assign arr_read  = take_s;
    assign arr_reset = reset || (state_r == ST_CLEAR);
    assign busy      = (state_r != ST_IDLE);
    assign done      = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a behavioural 4-PE array and a result scoreboard.
module tb_systolic_sequencer;
    localparam int PE = 4;
    localparam int WS = 16;
    localparam int LW = 16;

    typedef struct packed {
        logic [WS-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          arr_read, arr_reset, busy, done;
    logic [WS-1:0] arr_l_d_i, arr_l_d_o;
    logic [WS-1:0] arr_t_w [PE];

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, cmd_cnt = 0, cmd_cyc = 0;
    int clr_cnt = 0, res_seen = 0;
    exp_t sb [$];
    exp_t e_m;
    logic [WS-1:0] exp_acc [PE];

    logic [WS-1:0] st_d [PE];
    logic [WS-1:0] st_w [PE][PE];
    logic [WS-1:0] acc [PE];

    systolic_sequencer_if #(.WORD_SIZE(WS), .PE_NUMBER(PE), .LEN_W(LW)) bus ();

    systolic_sequencer #(.PE_NUMBER(PE), .WORD_SIZE(WS), .LEN_W(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .arr_read  (arr_read),
        .arr_reset (arr_reset),
        .arr_l_d_i (arr_l_d_i),
        .arr_t_w   (arr_t_w),
        .arr_l_d_o (arr_l_d_o),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Array model: data and weight vector ripple one PE per cycle; read shifts results toward PE0.
    always @(posedge clk) begin
        if (arr_reset) begin
            for (int j = 0; j < PE; j++) begin
                st_d[j] <= '0;
                acc[j]  <= '0;
                for (int i = 0; i < PE; i++) st_w[j][i] <= '0;
            end
        end else begin
            st_d[0] <= arr_l_d_i;
            for (int i = 0; i < PE; i++) st_w[0][i] <= arr_t_w[i];
            for (int j = 1; j < PE; j++) begin
                st_d[j] <= st_d[j-1];
                for (int i = 0; i < PE; i++) st_w[j][i] <= st_w[j-1][i];
            end
            if (arr_read) begin
                for (int j = 0; j < PE - 1; j++) acc[j] <= acc[j+1];
                acc[PE-1] <= '0;
            end else begin
                for (int j = 0; j < PE; j++) acc[j] <= acc[j] + st_d[j] * st_w[j][j];
            end
        end
    end
    assign arr_l_d_o = acc[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Monitor: event counters plus scoreboard pop on every accepted result.
    always @(negedge clk) begin
        if (!reset) begin
            if (arr_reset) clr_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                cmd_cnt++;
                cmd_cyc = cyc;
            end
            if (bus.res_valid && bus.res_ready) begin
                res_seen++;
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e_m = sb.pop_front();
                    chk("res_data", bus.res_data, e_m.data);
                    chk("res_last", bus.res_last, e_m.last);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_expected();
        for (int j = 0; j < PE; j++) begin
            sb.push_back('{data: exp_acc[j], last: (j == PE - 1)});
            exp_acc[j] = '0;
        end
    endtask

    task automatic send_cmd(input logic [LW-1:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = len;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
        end
        chk("cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic feed(input int k, input bit bubbles, input logic [WS-1:0] d0,
                        input logic [WS-1:0] wbase, input bit wvary);
        logic [WS-1:0] d;
        logic [WS-1:0] w [PE];
        for (int b = 0; b < k; b++) begin
            d = d0 + WS'(b);
            if (bubbles && b > 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'hDEAD;
                @(negedge clk);
                chk("bubble_in_ready", bus.in_ready, 1'b1);
                chk("bubble_l_d_i", arr_l_d_i, 16'd0);
                chk("bubble_t_w0", arr_t_w[0], 16'd0);
                @(posedge clk); #1;
            end
            for (int j = 0; j < PE; j++) begin
                w[j] = wvary ? (wbase + WS'(j)) : wbase;
                bus.in_weight[j] = w[j];
            end
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (bus.in_ready) break;
            end
            chk("beat_in_ready", bus.in_ready, 1'b1);
            chk("beat_l_d_i", arr_l_d_i, d);
            chk("beat_t_w0", arr_t_w[0], w[0]);
            chk("beat_t_w3", arr_t_w[PE-1], w[PE-1]);
            for (int j = 0; j < PE; j++) exp_acc[j] = exp_acc[j] + d * w[j];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        for (int j = 0; j < PE; j++) bus.in_weight[j] = '0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", done, 1'b1);
        @(posedge clk); #1;
    endtask

    int d0, c0, r0, m0;

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_len = '0;
        bus.in_valid = 1'b0;  bus.in_data = '0;
        bus.res_ready = 1'b1;
        for (int j = 0; j < PE; j++) begin
            bus.in_weight[j] = '0;
            exp_acc[j] = '0;
        end
        @(negedge clk);
        chk("rst_arr_reset", arr_reset, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_arr_read", arr_read, 1'b0);
        chk("rst_arr_reset", arr_reset, 1'b0);
        chk("rst_l_d_i", arr_l_d_i, 16'd0);
        chk("rst_t_w2", arr_t_w[2], 16'd0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_data", bus.res_data, 16'd0);
        chk("rst_res_last", bus.res_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk); #1;

        // Job 1: K=4, data 1..4, unit weights, no stalls.
        d0 = done_cnt; c0 = clr_cnt; r0 = res_seen;
        send_cmd(16'd4);
        feed(4, 1'b0, 16'd1, 16'd1, 1'b0);
        push_expected();
        wait_done();
        chk("j1_done_once", done_cnt - d0, 1);
        chk("j1_clear_once", clr_cnt - c0, 1);
        chk("j1_results", res_seen - r0, 4);
        chk("j1_latency", done_cyc - cmd_cyc, 14);
        chk("j1_sb_empty", sb.size(), 0);

        // Job 2: same job with bubbles between beats.
        r0 = res_seen;
        send_cmd(16'd4);
        feed(4, 1'b1, 16'd1, 16'd1, 1'b0);
        push_expected();
        wait_done();
        chk("j2_results", res_seen - r0, 4);

        // Job 3: K=0 skips FEED.
        d0 = done_cnt; r0 = res_seen;
        send_cmd(16'd0);
        chk("j3_no_feed", bus.in_ready, 1'b0);
        push_expected();
        wait_done();
        chk("j3_done_once", done_cnt - d0, 1);
        chk("j3_results", res_seen - r0, 4);
        chk("j3_latency", done_cyc - cmd_cyc, 10);

        // Job 4: downstream stall for 5 cycles after the first result; per-PE weights.
        r0 = res_seen;
        bus.res_ready = 1'b0;
        send_cmd(16'd3);
        feed(3, 1'b0, 16'd2, 16'd1, 1'b1);
        push_expected();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.res_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", bus.res_valid, 1'b1);
            chk("stall_data", bus.res_data, 16'd9);
            chk("stall_no_read", arr_read, 1'b0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        wait_done();
        chk("j4_results", res_seen - r0, 4);
        chk("j4_sb_empty", sb.size(), 0);

        // Job 5: reset in READ after two accepted results.
        d0 = done_cnt; r0 = res_seen;
        send_cmd(16'd4);
        feed(4, 1'b0, 16'd1, 16'd1, 1'b0);
        push_expected();
        for (int t = 0; t < 300; t++) begin
            @(posedge clk); #1;
            if (res_seen - r0 == 2) break;
        end
        chk("j5_two_results", res_seen - r0, 2);
        reset = 1'b1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk("j5_arr_reset", arr_reset, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("j5_idle", busy, 1'b0);
        chk("j5_cmd_ready", bus.cmd_ready, 1'b1);
        chk("j5_res_valid", bus.res_valid, 1'b0);
        chk("j5_pending", sb.size(), 2);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("j5_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;

        // Job 6: K=1, in=2, weights 3.
        send_cmd(16'd1);
        feed(1, 1'b0, 16'd2, 16'd3, 1'b0);
        push_expected();
        wait_done();
        chk("j6_sb_empty", sb.size(), 0);

        // Job 7: cmd_valid held through a job; back-to-back acceptance.
        m0 = cmd_cnt;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 16'd2;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
        end
        @(posedge clk); #1;
        feed(2, 1'b0, 16'd5, 16'd1, 1'b1);
        push_expected();
        wait_done();
        @(negedge clk);
        chk("b2b_accept_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("b2b_after_done", cmd_cyc - done_cyc, 1);
        feed(2, 1'b0, 16'd7, 16'd2, 1'b0);
        push_expected();
        wait_done();
        chk("b2b_cmd_count", cmd_cnt - m0, 2);
        chk("b2b_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
